neuron_controller: RTL and testbench

//  Control FSM driving one Neuron_DataPath instance (the other end of its control interface).
//  On a start request it clears the accumulator, sweeps the input offset over all N lanes with ld asserted,

---
 rtl/neuron_pkg.sv | 18 +
 rtl/neuron_offset_counter.sv | 33 +++
 rtl/neuron_controller.sv | 131 +++++++++++++
 tb/tb_neuron_controller.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/neuron_pkg.sv
// Shared types and helpers for the neuron control path: state encoding and
// the lane-select width derived from the number of inputs per neuron.
package neuron_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_CLR  = 3'd1,
    ST_ACC  = 3'd2,
    ST_ACT  = 3'd3,
    ST_HOLD = 3'd4
  } state_t;

  // Clamped to 1 so a degenerate N still yields a legal one-bit lane select.
  function automatic int offset_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/neuron_offset_counter.sv
// Lane-select counter for the accumulate sweep: counts 0..N-1 while enabled,
// wraps to 0 after the terminal lane and flags that terminal lane.
module neuron_offset_counter #(
  parameter int N  = 10,
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_clr,
  input  logic          i_en,
  output logic [CW-1:0] o_count,
  output logic          o_last
);

  localparam logic [CW-1:0] LAST = CW'(N - 1);

  logic [CW-1:0] r_count;

  assign o_count = r_count;
  assign o_last  = (r_count == LAST);

  // Wrapping on the terminal lane keeps the count inside 0..N-1 for any N.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= o_last ? '0 : r_count + CW'(1);
    end
  end

endmodule

// File: rtl/neuron_controller.sv
// Control FSM for one neuron datapath: clear, sweep all lanes with load,
// one activation cycle, then hold the captured result under valid/ack.
module neuron_controller
  import neuron_pkg::*;
#(
  parameter int N  = 10,
  parameter int DW = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         layer_hidden,
  input  logic [DW-1:0]                dp_result,
  output logic                         acc_clr,
  output logic                         ld,
  output logic [offset_width(N)-1:0]   offset,
  output logic                         hidden,
  output logic                         ready,
  output logic                         busy,
  output logic [DW-1:0]                out_data,
  output logic                         out_valid,
  input  logic                         out_ack
);

  localparam int CW = offset_width(N);

  state_t        r_state;
  logic          r_acc_clr;
  logic          r_ld;
  logic          r_ready;
  logic          r_busy;
  logic          r_hidden;
  logic          r_out_valid;
  logic [DW-1:0] r_out_data;
  logic [CW-1:0] w_offset;
  logic          w_last;

  // r_ld is high exactly in ACC, so it doubles as the counter enable.
  neuron_offset_counter #(
    .N  (N),
    .CW (CW)
  ) u_offset_counter (
    .clk     (clk),
    .rst     (rst),
    .i_clr   (!r_ld),
    .i_en    (r_ld),
    .o_count (w_offset),
    .o_last  (w_last)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= ST_IDLE;
      r_acc_clr <= 1'b0;
      r_ld      <= 1'b0;
      r_ready   <= 1'b0;
      r_busy    <= 1'b0;
      r_hidden  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state   <= ST_CLR;
            r_hidden  <= layer_hidden;
            r_acc_clr <= 1'b1;
            r_busy    <= 1'b1;
          end
        end
        ST_CLR: begin
          r_state   <= ST_ACC;
          r_acc_clr <= 1'b0;
          r_ld      <= 1'b1;
        end
        ST_ACC: begin
          if (w_last) begin
            r_state <= ST_ACT;
            r_ld    <= 1'b0;
            r_ready <= 1'b1;
          end
        end
        ST_ACT: begin
          r_state <= ST_HOLD;
          r_ready <= 1'b0;
        end
        ST_HOLD: begin
          // Ack together with a new start chains straight into CLR.
          if (out_ack) begin
            if (start) begin
              r_state   <= ST_CLR;
              r_hidden  <= layer_hidden;
              r_acc_clr <= 1'b1;
            end else begin
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
            end
          end
        end
        default: begin
          r_state   <= ST_IDLE;
          r_acc_clr <= 1'b0;
          r_ld      <= 1'b0;
          r_ready   <= 1'b0;
          r_busy    <= 1'b0;
        end
      endcase
    end
  end

  // Result capture happens on the edge that leaves ACT.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else if (r_ready) begin
      r_out_valid <= 1'b1;
      r_out_data  <= dp_result;
    end else if (r_out_valid && out_ack) begin
      r_out_valid <= 1'b0;
    end
  end

  assign acc_clr   = r_acc_clr;
  assign ld        = r_ld;
  assign offset    = w_offset;
  assign hidden    = r_hidden;
  assign ready     = r_ready;
  assign busy      = r_busy;
  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;

endmodule

// File: tb/tb_neuron_controller.sv
// Bench for neuron_controller: N=10 and N=5 instances share one stimulus stream
// and are compared against a per-run phase model plus a result scoreboard.
module tb_neuron_controller;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       start;
  logic       layer_hidden;
  logic       out_ack;
  logic [7:0] dp_result;

  logic       clr0, ld0, hid0, rdy0, busy0, val0;
  logic [3:0] off0;
  logic [7:0] data0;
  logic       clr1, ld1, hid1, rdy1, busy1, val1;
  logic [2:0] off1;
  logic [7:0] data1;

  neuron_controller #(.N(10), .DW(8)) u_n10 (
    .clk(clk), .rst(rst), .start(start), .layer_hidden(layer_hidden),
    .dp_result(dp_result), .acc_clr(clr0), .ld(ld0), .offset(off0),
    .hidden(hid0), .ready(rdy0), .busy(busy0), .out_data(data0),
    .out_valid(val0), .out_ack(out_ack)
  );

  neuron_controller #(.N(5), .DW(8)) u_n5 (
    .clk(clk), .rst(rst), .start(start), .layer_hidden(layer_hidden),
    .dp_result(dp_result), .acc_clr(clr1), .ld(ld1), .offset(off1),
    .hidden(hid1), .ready(rdy1), .busy(busy1), .out_data(data1),
    .out_valid(val1), .out_ack(out_ack)
  );

  typedef struct {
    logic [7:0] data;
    logic       hid;
    int         edge_n;
  } rec_t;

  rec_t sb0[$];
  rec_t sb1[$];
  int   n_chk = 0;
  int   n_fail = 0;

  // Reference model: per lane, whether a run is in progress, the edge at
  // which it was accepted, and the latched hidden flag / captured result.
  int         m_e = 0;
  bit         m_act[2];
  int         m_s[2];
  logic       m_hid[2];
  logic [7:0] m_data[2];
  logic       pv[2] = '{1'b0, 1'b0};

  function automatic int lane_n(input int l);
    return (l == 0) ? 10 : 5;
  endfunction

  function automatic bit in_hold(input int l);
    return m_act[l] && ((m_e - m_s[l]) >= lane_n(l) + 2);
  endfunction

  task automatic model_reset();
    for (int l = 0; l < 2; l++) begin
      m_act[l]  = 1'b0;
      m_s[l]    = 0;
      m_hid[l]  = 1'b0;
      m_data[l] = 8'h00;
    end
    sb0.delete();
    sb1.delete();
  endtask

  // Phase p of the cycle ending at this edge: 0 = clear, 1..N = load lanes,
  // N+1 = activation, >= N+2 = holding the result.
  task automatic model_edge();
    m_e++;
    if (rst) begin
      for (int l = 0; l < 2; l++) begin
        int n;
        int p;
        rec_t r;
        n = lane_n(l);
        p = m_e - 1 - m_s[l];
        if (!m_act[l]) begin
          if (start) begin
            m_act[l] = 1'b1;
            m_s[l]   = m_e;
            m_hid[l] = layer_hidden;
          end
        end else if (p == n + 1) begin
          m_data[l] = dp_result;
          r.data    = dp_result;
          r.hid     = m_hid[l];
          r.edge_n  = m_e;
          if (l == 0) sb0.push_back(r);
          else        sb1.push_back(r);
        end else if (p >= n + 2 && out_ack) begin
          if (start) begin
            m_s[l]   = m_e;
            m_hid[l] = layer_hidden;
          end else begin
            m_act[l] = 1'b0;
          end
        end
      end
    end
  endtask

  task automatic step(input logic st, input logic hd, input logic [7:0] dp, input logic ack);
    @(posedge clk);
    model_edge();
    #1;
    rst          = 1'b1;
    start        = st;
    layer_hidden = hd;
    dp_result    = dp;
    out_ack      = ack;
  endtask

  task automatic do_reset();
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic chk(input int l, input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL lane%0d(N=%0d) %s at edge %0d: got %0d, expected %0d",
               l, lane_n(l), nm, m_e, act, exp);
    end
  endtask

  task automatic check_lane(input int l, input logic clr, input logic ldv, input int off,
                            input logic rdy, input logic bsy, input logic val,
                            input logic hid, input logic [7:0] data);
    int   n;
    int   q;
    bit   in_acc;
    bit   empty;
    rec_t r;
    n      = lane_n(l);
    q      = m_act[l] ? (m_e - m_s[l]) : -1;
    in_acc = (q >= 1) && (q <= n);
    chk(l, "acc_clr",   int'(clr), int'(q == 0));
    chk(l, "ld",        int'(ldv), int'(in_acc));
    chk(l, "offset",    off, in_acc ? q - 1 : 0);
    chk(l, "ready",     int'(rdy), int'(q == n + 1));
    chk(l, "busy",      int'(bsy), int'(m_act[l]));
    chk(l, "out_valid", int'(val), int'(q >= n + 2));
    chk(l, "hidden",    int'(hid), int'(m_hid[l]));
    if (val || !rst) chk(l, "out_data", int'(data), int'(m_data[l]));
    if (val && !pv[l]) begin
      empty = (l == 0) ? (sb0.size() == 0) : (sb1.size() == 0);
      if (empty) begin
        n_chk++;
        n_fail++;
        $display("FAIL lane%0d sb_empty: out_valid rose at edge %0d with no expected result", l, m_e);
      end else begin
        r = (l == 0) ? sb0.pop_front() : sb1.pop_front();
        chk(l, "sb_data", int'(data), int'(r.data));
        chk(l, "sb_hidden", int'(hid), int'(r.hid));
        chk(l, "sb_edge", m_e, r.edge_n);
      end
    end
    pv[l] = val;
  endtask

  always @(negedge clk) begin
    check_lane(0, clr0, ld0, int'(off0), rdy0, busy0, val0, hid0, data0);
    check_lane(1, clr1, ld1, int'(off1), rdy1, busy1, val1, hid1, data1);
  end

  initial begin
    rst          = 1'b0;
    start        = 1'b0;
    layer_hidden = 1'b0;
    out_ack      = 1'b0;
    dp_result    = 8'h00;
    model_reset();
    repeat (2) @(posedge clk);
    step(1'b0, 1'b0, 8'h5A, 1'b0);

    // One run with a fixed activation value.
    step(1'b1, 1'b0, 8'h5A, 1'b0);
    for (int i = 0; i < 40 && !in_hold(0); i++) step(1'b0, 1'b0, 8'h5A, 1'b0);

    // Backpressure: new datapath value and a start pulse while unacknowledged.
    for (int i = 0; i < 6; i++) step(i == 2, 1'b1, 8'h11, 1'b0);

    // Ack and start in the same cycle with hidden scaling requested.
    step(1'b1, 1'b1, 8'h33, 1'b1);
    step(1'b0, 1'b0, 8'h44, 1'b0);
    for (int i = 0; i < 40 && !in_hold(0); i++) step(1'b0, 1'b0, 8'($urandom), 1'b0);

    // Restart, then abort with reset while the sweep is on lane 4.
    step(1'b1, 1'b0, 8'h77, 1'b1);
    for (int i = 0; i < 40; i++) begin
      step(1'b0, 1'b0, 8'($urandom), 1'b0);
      if (m_act[0] && (m_e - m_s[0]) == 5) break;
    end
    do_reset();
    for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 8'($urandom), 1'b0);

    // Random traffic, including starts during runs and occasional resets.
    for (int i = 0; i < 800; i++) begin
      step($urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)), 8'($urandom),
           $urandom_range(0, 2) == 0);
      if ($urandom_range(0, 149) == 0) do_reset();
    end
    step(1'b0, 1'b0, 8'h00, 1'b1);
    step(1'b0, 1'b0, 8'h00, 1'b0);
    @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
